// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V U-type encoding definitions.
// Holds the LUI/AUIPC opcode constants, the U-type field widths, a packed
// field struct and the helpers that pack fields into a word and recognise a
// U-type opcode. The encoder RTL and the decoder-side bench both use them.
package riscv_pkg;

  localparam int unsigned IMM_U_W = 20;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned INST_W  = IMM_U_W + RD_W + OPC_W;

  localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [IMM_U_W-1:0] imm;
    logic [RD_W-1:0]    rd;
    logic [OPC_W-1:0]   opcode;
  } utype_fields_t;

  // inst[31:12] = imm, inst[11:7] = rd, inst[6:0] = opcode
  function automatic logic [INST_W-1:0] encode_utype(input utype_fields_t f);
    return {f.imm, f.rd, f.opcode};
  endfunction

  function automatic logic is_utype_opcode(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LUI) || (opc == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous flush (wins over push/pop)
//   push_i, wdata_i write request and data; ignored when full
//   pop_i           read request; ignored when empty
//   rdata_o         head entry (only meaningful while !empty_o)
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries
// Depth must be a power of two: pointers wrap by natural overflow.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // No pass-through: a push into a full FIFO is dropped even if a pop
  // frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed while count_q != 0.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/riscv_utype_encoder.sv
// riscv_utype_encoder: packs LUI/AUIPC field sets into 32-bit instructions
// and streams them, tagged with a sequential word address, through a small
// output FIFO towards instruction memory.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous flush of FIFO and address counter
//   in_valid/in_ready   field-set handshake; in_imm, in_rd, in_opcode fields
//   out_valid/out_ready instruction handshake; out_inst, out_addr payload
//   err_illegal         one-cycle pulse per dropped (illegal-opcode) field set
//   illegal_count       saturating count of dropped field sets
module riscv_utype_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IMM_U_W-1:0] in_imm,
  input  logic [RD_W-1:0]    in_rd,
  input  logic [OPC_W-1:0]   in_opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INST_W-1:0]  out_inst,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               err_illegal,
  output logic [7:0]         illegal_count
);

  localparam int unsigned EntryW = INST_W + ADDR_W;
  localparam int unsigned OccW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  logic                 in_fire, legal, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [OccW-1:0]      occupancy;
  logic [EntryW-1:0]    fifo_wdata, fifo_rdata;
  utype_fields_t        fields;

  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic                 err_q, err_d;
  logic [7:0]           cnt_q, cnt_d;

  // Handshake and opcode check
  assign in_ready = !fifo_full && !clear;
  assign in_fire  = in_valid && in_ready;
  assign legal    = is_utype_opcode(in_opcode);
  assign push     = in_fire && legal;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  assign fields     = '{imm: in_imm, rd: in_rd, opcode: in_opcode};
  assign fifo_wdata = {encode_utype(fields), wr_addr_q};

  // Present reset values whenever nothing is queued so stale storage never
  // leaks onto the memory bus.
  assign out_inst = out_valid ? fifo_rdata[EntryW-1:ADDR_W] : '0;
  assign out_addr = out_valid ? fifo_rdata[ADDR_W-1:0] : BaseAddr;

  assign err_illegal   = err_q;
  assign illegal_count = cnt_q;

  sync_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  // Address counter, error pulse and saturating drop counter
  always_comb begin
    wr_addr_d = wr_addr_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    if (clear) begin
      // illegal_count deliberately survives a clear
      wr_addr_d = BaseAddr;
    end else begin
      if (push) begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
      if (in_fire && !legal) begin
        err_d = 1'b1;
        if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= BaseAddr;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // FIFO flags must agree with its occupancy count
  a_flags_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_full == (occupancy == OccW'(FIFO_DEPTH))) &&
    (fifo_empty == (occupancy == '0)));

endmodule

// File: tb/tb_riscv_utype_encoder.sv
module tb_riscv_utype_encoder;

  localparam int unsigned Depth = 4;
  localparam int unsigned AddrW = 8;
  localparam int unsigned Base  = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_imm = '0;
  logic [4:0]  in_rd = '0;
  logic [6:0]  in_opcode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [7:0]  out_addr;
  logic        err_illegal;
  logic [7:0]  illegal_count;

  always #5 clk = ~clk;

  riscv_utype_encoder #(
    .FIFO_DEPTH (Depth),
    .ADDR_W     (AddrW),
    .BASE_ADDR  (Base)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_imm        (in_imm),
    .in_rd         (in_rd),
    .in_opcode     (in_opcode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_addr      (out_addr),
    .err_illegal   (err_illegal),
    .illegal_count (illegal_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of {inst, addr} words awaiting the consumer
  logic [39:0] exp_q[$];
  int          exp_addr = Base;
  int          exp_cnt  = 0;
  bit          exp_err  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_addr = Base;
    exp_cnt  = 0;
    exp_err  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    check_eq({tag, "_out_valid"}, out_valid, 1'b0);
    check_eq({tag, "_out_inst"}, out_inst, 32'h0);
    check_eq({tag, "_out_addr"}, out_addr, Base);
    check_eq({tag, "_err"}, err_illegal, 1'b0);
    check_eq({tag, "_count"}, illegal_count, 8'd0);
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle against the
  // model, then advance the model across the rising edge.
  task automatic cycle(input bit v, input logic [19:0] imm, input logic [4:0] rd,
                       input logic [6:0] opc, input bit ordy, input bit clr);
    bit exp_ready, fire, legal, do_pop;
    in_valid  = v;
    in_imm    = imm;
    in_rd     = rd;
    in_opcode = opc;
    out_ready = ordy;
    clear     = clr;
    @(negedge clk);
    exp_ready = (exp_q.size() < Depth) && !clr;
    check_eq("in_ready", in_ready, exp_ready);
    check_eq("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check_eq("out_inst", out_inst, exp_q[0][39:8]);
      check_eq("out_addr", out_addr, exp_q[0][7:0]);
    end
    check_eq("err_illegal", err_illegal, exp_err);
    check_eq("illegal_count", illegal_count, exp_cnt);
    legal  = (opc == 7'h37) || (opc == 7'h17);
    fire   = v && exp_ready;
    do_pop = (exp_q.size() != 0) && ordy;
    @(posedge clk);
    if (clr) begin
      exp_q.delete();
      exp_addr = Base;
      exp_err  = 1'b0;
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      exp_err = fire && !legal;
      if (fire && legal) begin
        exp_q.push_back({imm, rd, opc, 8'(exp_addr)});
        exp_addr = (exp_addr + 1) % (1 << AddrW);
      end
      if (fire && !legal && exp_cnt < 255) exp_cnt++;
    end
    #1;
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 20'h0, 5'd0, 7'h37, ordy, 1'b0);
  endtask

  function automatic logic [6:0] rand_opc();
    case ($urandom_range(0, 3))
      0:       return 7'h37;
      1:       return 7'h17;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    // Reset state
    #12;
    check_reset_outputs("por");
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // LUI, then AUIPC, with explicit expected words
    cycle(1'b1, 20'h12345, 5'd12, 7'h37, 1'b1, 1'b0);
    check_eq("lui_inst", out_inst, 32'h12345637);
    check_eq("lui_addr", out_addr, 8'd0);
    cycle(1'b1, 20'hABCDE, 5'd31, 7'h17, 1'b1, 1'b0);
    check_eq("auipc_inst", out_inst, 32'hABCDEF97);
    check_eq("auipc_addr", out_addr, 8'd1);
    idle(1'b1);

    // Illegal opcode: pulse, count, address not consumed
    cycle(1'b1, 20'h55555, 5'd3, 7'h78, 1'b1, 1'b0);
    check_eq("ill_pulse", err_illegal, 1'b1);
    check_eq("ill_count", illegal_count, 8'd1);
    cycle(1'b1, 20'h00001, 5'd0, 7'h37, 1'b1, 1'b0);
    check_eq("ill_pulse_end", err_illegal, 1'b0);
    check_eq("after_ill_addr", out_addr, 8'd2);
    check_eq("rd0_inst", out_inst, 32'h00001037);
    idle(1'b1);

    // Back-pressure from a fresh address space
    cycle(1'b0, 20'h0, 5'd0, 7'h37, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 20'(i + 16), 5'(i), 7'h37, 1'b0, 1'b0);
    check_eq("bp_in_ready", in_ready, 1'b0);
    check_eq("bp_head_addr", out_addr, 8'd0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 20'($urandom), 5'($urandom), rand_opc(),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Address wrap: 258 legal words after a clear
    cycle(1'b0, 20'h0, 5'd0, 7'h37, 1'b1, 1'b1);
    for (int i = 0; i < 258; i++) cycle(1'b1, 20'($urandom), 5'($urandom), 7'h17, 1'b1, 1'b0);
    check_eq("wrap_last_addr", out_addr, 8'd1);
    idle(1'b1);

    // Counter saturation
    for (int i = 0; i < 300; i++) cycle(1'b1, 20'h0, 5'd0, 7'h7F, 1'b1, 1'b0);
    idle(1'b1);
    check_eq("count_sat", illegal_count, 8'd255);
    idle(1'b1);

    // Clear mid-stream: queued words dropped, count kept
    for (int i = 0; i < 3; i++) cycle(1'b1, 20'(i + 100), 5'd7, 7'h37, 1'b0, 1'b0);
    cycle(1'b1, 20'hFFFFF, 5'd9, 7'h37, 1'b0, 1'b1);
    check_eq("clr_out_valid", out_valid, 1'b0);
    check_eq("clr_count_kept", illegal_count, 8'd255);
    cycle(1'b1, 20'h00ABC, 5'd1, 7'h37, 1'b1, 1'b0);
    check_eq("clr_next_addr", out_addr, Base);
    idle(1'b1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cycle(1'b1, 20'(i + 200), 5'd2, 7'h17, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) idle(1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 20'($urandom), 5'($urandom), rand_opc(), ($urandom_range(0, 1) != 0), 1'b0);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_utype_encoder.md
# riscv_utype_encoder

Assembles RISC-V U-type instructions (LUI/AUIPC) from separate fields and streams the packed 32-bit words, each tagged with a sequential word address, towards instruction memory. It is the encode-side counterpart of the U-type field decoder and sits between the test/program loader and the instruction memory write port. Illegal opcodes are rejected and counted. A small output FIFO decouples the field producer from memory back-pressure.

## Interface
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2
- ADDR_W, 8, width of the word address tag
- BASE_ADDR, 0, first address issued after reset or clear
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous assert and active-low; one clock, no other clock domains
- clear  in  1  synchronous flush of the FIFO and address counter
- in_valid  in  1  field set present
- in_ready  out  1  encoder can accept a field set
- in_imm  in  20  immediate, becomes inst[31:12]
- in_rd  in  5  destination register, becomes inst[11:7]
- in_opcode  in  7  opcode, becomes inst[6:0]
- out_valid  out  1  head FIFO entry valid
- out_ready  in  1  consumer accepts the head entry
- out_inst  out  32  packed instruction
- out_addr  out  ADDR_W  word address of out_inst
- err_illegal  out  1  one-cycle pulse, illegal opcode dropped
- illegal_count  out  8  saturating count of dropped field sets

## Operation
- Input transfer when in_valid && in_ready; in_ready = !full && !clear.
- Legal opcodes: 7'b0110111 (LUI), 7'b0010111 (AUIPC). Anything else is illegal.
- Legal transfer: inst = {in_imm, in_rd, in_opcode} pushed with the current write address; write address increments by 1 modulo 2^ADDR_W (wraps silently).
- Illegal transfer: handshake completes, nothing pushed, address not incremented, err_illegal high the following cycle, illegal_count += 1, saturating at 255.
- rd = 0 is legal and encoded unchanged.
- Output transfer when out_valid && out_ready; head entry popped.
- While out_valid && !out_ready, out_inst and out_addr stay stable.
- Simultaneous push and pop permitted whenever not full; occupancy unchanged.
- No push when full, even if a pop occurs the same cycle (no pass-through).
- clear: empties FIFO, write address reset to BASE_ADDR, err_illegal cleared; illegal_count preserved; any input presented that cycle is not accepted.

## Timing
- Reset values: in_ready 1, out_valid 0, out_inst 0, out_addr BASE_ADDR, err_illegal 0, illegal_count 0; write address BASE_ADDR.
- Latency: legal transfer in cycle N, out_valid high in cycle N+1 if FIFO was empty.
- Throughput: one instruction per cycle in and out at steady state.
- in_ready falls the cycle after the FIFO reaches FIFO_DEPTH entries; rises the cycle after a pop from full.
- err_illegal: registered, exactly one cycle per illegal transfer; back-to-back illegal transfers hold it high continuously.
- Reset asserted mid-stream: all entries discarded immediately (asynchronous), outputs at reset values; no partial words emitted after release.
- Precedence: rst_n > clear > push/pop.

## Structure
- Shared package riscv_pkg: OPC_LUI, OPC_AUIPC constants, U-type field widths (IMM_U_W=20, RD_W=5, OPC_W=7), and the encode function used here and by the decoder bench.
- One natural sub-module: sync_fifo (parameterised width/depth, full/empty, occupancy count), instantiated with width 32+ADDR_W.
- Top level holds opcode check, address counter, error pulse/counter, handshake logic.

## Test plan
- LUI: imm 0x12345, rd 12, opcode 0x37, out_ready 1 -> out_inst 0x12345637, out_addr 0 one cycle later.
- AUIPC: imm 0xABCDE, rd 31, opcode 0x17 -> out_inst 0xABCDEF97, addr one greater than previous.
- Illegal: opcode 0x78 -> no output, err_illegal one-cycle pulse, illegal_count 1, next legal word gets unincremented address.
- Back-pressure: out_ready 0, push 5 legal words -> in_ready low after 4th, out_inst frozen at first word; release -> 4 words in order, addresses 0..3.
- Wrap: ADDR_W 8, 258 legal words -> addresses 0..255, 0, 1; illegal_count saturates at 255 after 300 illegal words.
- Reset/clear mid-stream: 3 entries queued, pulse clear -> out_valid 0 next cycle, next word addr BASE_ADDR, illegal_count kept; rst_n low asynchronously -> all outputs at reset values before next edge.
